// File: rtl/rr_burst_arbiter_pkg.sv
// rr_burst_arbiter_pkg: FSM encoding, burst counter sizing and clog2 helper
package rr_burst_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    localparam int BURST_W = 8;
    localparam int BURST_SAT = (1 << BURST_W) - 1;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rr_burst_arbiter_if.sv
// rr_burst_arbiter_if: channel request/data bundle and merged output stream
interface rr_burst_arbiter_if import rr_burst_arbiter_pkg::*; #(
    parameter int WIDTH = 5,
    parameter int DSIZE = 32,
    parameter int IDW   = clog2(WIDTH)
);
    logic [WIDTH-1:0]       CH_ENABLE;
    logic [WIDTH-1:0]       WRITE_REQ;
    logic [WIDTH-1:0]       HOLD_REQ;
    logic [WIDTH*DSIZE-1:0] DATA_IN;
    logic [WIDTH-1:0]       READ_GRANT;
    logic                   READY_OUT;
    logic                   WRITE_OUT;
    logic [DSIZE-1:0]       DATA_OUT;
    logic [IDW-1:0]         CHANNEL_OUT;
    logic [WIDTH-1:0]       GRANT_OUT;
    modport master (
        output CH_ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, CHANNEL_OUT, GRANT_OUT
    );
    modport slave (
        input  CH_ENABLE, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
        output READ_GRANT, WRITE_OUT, DATA_OUT, CHANNEL_OUT, GRANT_OUT
    );
endinterface

// File: rtl/rr_burst_arbiter_priority_select.sv
// rr_priority_select: rotating-priority encoder, searches last+1, last+2, ... with wrap
module rr_priority_select import rr_burst_arbiter_pkg::*; #(
    parameter int WIDTH = 5,
    parameter int IDW   = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDW-1:0]   last_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic [IDW-1:0]   idx_o
);
    logic [IDW-1:0] k;
    // walk from the farthest candidate to the nearest so the nearest match wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        k     = '0;
        for (int i = WIDTH; i >= 1; i--) begin
            k = IDW'((int'(last_i) + i) % WIDTH);
            if (req_i[k]) begin
                gnt_o = WIDTH'(1) << k;
                idx_o = k;
            end
        end
    end
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin merge of N FWFT FIFOs with enable mask, bounded bursts and hold
module rr_burst_arbiter import rr_burst_arbiter_pkg::*; #(
    parameter  int WIDTH     = 5,
    parameter  int DSIZE     = 32,
    parameter  int MAX_BURST = 16,
    localparam int IDW       = clog2(WIDTH)
) (
    input logic CLK,
    input logic RSTn,
    rr_burst_arbiter_if.slave bus
);
    state_t               state_q, state_d;
    logic [IDW-1:0]       owner_q, owner_d, last_q, last_d, chan_q, chan_d, sel_idx;
    logic [BURST_W-1:0]   burst_q, burst_d, burst_inc;
    logic [DSIZE-1:0]     data_q, data_d;
    logic                 wr_q, wr_d, granted, pop, rel;
    logic [WIDTH-1:0]     eligible, sel_onehot;
    logic [DSIZE-1:0]     din [WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_din
        assign din[g] = bus.DATA_IN[g*DSIZE +: DSIZE];
    end

    rr_priority_select #(.WIDTH(WIDTH), .IDW(IDW)) u_sel (
        .req_i  (eligible),
        .last_i (last_q),
        .gnt_o  (sel_onehot),
        .idx_o  (sel_idx)
    );

    assign eligible  = bus.WRITE_REQ & bus.CH_ENABLE;
    assign granted   = state_q == GRANT;
    assign pop       = granted && eligible[owner_q] && bus.READY_OUT;
    assign burst_inc = (burst_q == BURST_W'(BURST_SAT)) ? burst_q : burst_q + 1'b1;
    // a held channel keeps the grant past MAX_BURST; only a disable breaks the hold
    assign rel = granted && (!bus.CH_ENABLE[owner_q]
                 || (!bus.WRITE_REQ[owner_q] && !bus.HOLD_REQ[owner_q])
                 || (pop && int'(burst_inc) >= MAX_BURST && !bus.HOLD_REQ[owner_q]));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (!granted && |sel_onehot) begin
            state_d = GRANT;
            owner_d = sel_idx;
            burst_d = '0;
        end
        if (pop) burst_d = burst_inc;
        if (rel) begin
            state_d = IDLE;
            last_d  = owner_q;
        end
    end

    assign wr_d   = pop;
    assign data_d = pop ? din[owner_q] : data_q;
    assign chan_d = pop ? owner_q : chan_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDW'(WIDTH - 1);
            burst_q <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign bus.READ_GRANT  = pop ? WIDTH'(1) << owner_q : '0;
    assign bus.GRANT_OUT   = granted ? WIDTH'(1) << owner_q : '0;
    assign bus.WRITE_OUT   = wr_q;
    assign bus.DATA_OUT    = data_q;
    assign bus.CHANNEL_OUT = chan_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: FIFO-emulating directed bench with a per-cycle reference model of the arbiter
module tb_rr_burst_arbiter;
    import rr_burst_arbiter_pkg::*;
    localparam int W  = 5;
    localparam int DS = 32;
    localparam int MB = 4;
    localparam int IW = clog2(W);

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DS-1:0] fq [W][$];
    logic [W-1:0] pend = '0;
    int log_ch [$];
    int log_cyc [$];
    logic [DS-1:0] log_d [$];

    bit m_grant;
    int m_own, m_last, m_cnt, m_chan;
    bit m_wr;
    logic [DS-1:0] m_data;

    always #5 CLK = ~CLK;

    rr_burst_arbiter_if #(.WIDTH(W), .DSIZE(DS), .IDW(IW)) bus ();
    rr_burst_arbiter #(.WIDTH(W), .DSIZE(DS), .MAX_BURST(MB)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < W; k++) begin
            bus.WRITE_REQ[k] = fq[k].size() != 0;
            bus.DATA_IN[k*DS +: DS] = (fq[k].size() != 0) ? fq[k][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        for (int k = 0; k < W; k++)
            if (pend[k] && fq[k].size() != 0) void'(fq[k].pop_front());
        pend = '0;
        apply();
    endtask

    task automatic clr_log();
        log_ch.delete();
        log_cyc.delete();
        log_d.delete();
    endtask

    // Reference model: owner rotates from the last released channel; a burst ends on
    // disable, on an empty unheld FIFO, or when an unheld pop reaches MB words.
    always @(negedge CLK) begin
        logic [W-1:0] elig;
        bit pop, rel;
        cyc++;
        if (!RSTn) begin
            m_grant = 0; m_own = 0; m_last = W - 1; m_cnt = 0;
            m_wr = 0; m_data = '0; m_chan = 0;
        end
        elig = bus.WRITE_REQ & bus.CH_ENABLE;
        pop  = RSTn && m_grant && elig[m_own] && bus.READY_OUT;
        chk("read_grant", bus.READ_GRANT, pop ? (W'(1) << m_own) : W'(0));
        chk("grant_out", bus.GRANT_OUT, m_grant ? (W'(1) << m_own) : W'(0));
        chk("write_out", bus.WRITE_OUT, m_wr);
        chk("data_out", bus.DATA_OUT, m_data);
        chk("channel_out", bus.CHANNEL_OUT, m_chan);
        if (bus.WRITE_OUT) begin
            log_ch.push_back(int'(bus.CHANNEL_OUT));
            log_cyc.push_back(cyc);
            log_d.push_back(bus.DATA_OUT);
        end
        pend = bus.READ_GRANT;
        if (RSTn) begin
            m_wr = pop;
            if (pop) begin
                m_data = bus.DATA_IN[m_own*DS +: DS];
                m_chan = m_own;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            if (m_grant) begin
                rel = !bus.CH_ENABLE[m_own] || (!bus.WRITE_REQ[m_own] && !bus.HOLD_REQ[m_own])
                      || (pop && m_cnt >= MB && !bus.HOLD_REQ[m_own]);
                if (rel) begin
                    m_grant = 0;
                    m_last  = m_own;
                end
            end else begin
                for (int i = 1; i <= W; i++)
                    if (!m_grant && elig[(m_last + i) % W]) begin
                        m_own = (m_last + i) % W; m_grant = 1; m_cnt = 0;
                    end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fair_exp [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};
        int n1;
        bus.CH_ENABLE = '1;
        bus.HOLD_REQ  = '0;
        bus.READY_OUT = 1'b1;
        bus.WRITE_REQ = '0;
        bus.DATA_IN   = '0;
        // reset with every channel requesting
        for (int k = 0; k < W; k++) fq[k].push_back(32'hF0 + 32'(k));
        apply();
        repeat (3) step();
        #1;
        chk("rst_write_out", bus.WRITE_OUT, 0);
        chk("rst_read_grant", bus.READ_GRANT, 0);
        chk("rst_grant_out", bus.GRANT_OUT, 0);
        chk("rst_data_out", bus.DATA_OUT, 0);
        for (int k = 0; k < W; k++) fq[k].delete();
        apply();
        RSTn = 1'b1;
        step();
        // single-channel burst: first word two cycles after the request
        for (int i = 0; i < 4; i++) fq[0].push_back(32'hA0 + 32'(i));
        apply();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("first_wr", bus.WRITE_OUT, (i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) begin
                chk("first_data", bus.DATA_OUT, 32'hA0 + 32'(i - 1));
                chk("first_chan", bus.CHANNEL_OUT, 0);
            end
        end
        // fairness with MB=4
        clr_log();
        for (int k = 1; k <= 3; k++)
            for (int i = 0; i < 8; i++) fq[k].push_back(32'(k * 256 + i));
        apply();
        for (int t = 0; t < 60 && log_ch.size() < 13; t++) step();
        chk("fair_count", log_ch.size(), 13);
        for (int i = 0; i < 13; i++)
            if (i < log_ch.size()) chk("fair_seq", log_ch[i], fair_exp[i]);
        if (log_cyc.size() >= 5) begin
            chk("fair_back2back", log_cyc[1] - log_cyc[0], 1);
            chk("fair_bubble", log_cyc[4] - log_cyc[3], 2);
        end
        for (int k = 0; k < W; k++) fq[k].delete();
        apply();
        repeat (4) step();
        // backpressure mid-burst
        clr_log();
        for (int i = 0; i < 6; i++) fq[4].push_back(32'h4400 + 32'(i));
        apply();
        step();
        step();
        bus.READY_OUT = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_read_grant", bus.READ_GRANT, 0);
            if (j > 0) chk("bp_write_out", bus.WRITE_OUT, 0);
            step();
        end
        bus.READY_OUT = 1'b1;
        chk("bp_write_out_end", bus.WRITE_OUT, 0);
        for (int t = 0; t < 20 && log_ch.size() < 6; t++) step();
        repeat (2) step();
        chk("bp_count", log_ch.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < log_d.size()) chk("bp_data", log_d[i], 32'h4400 + 32'(i));
        if (log_cyc.size() >= 5) begin
            chk("bp_resume", log_cyc[3] - log_cyc[2], 1);
            chk("bp_burst_end", log_cyc[4] - log_cyc[3], 2);
        end
        // hold keeps an idle channel past MB
        clr_log();
        bus.HOLD_REQ[2] = 1'b1;
        for (int i = 0; i < 6; i++) fq[2].push_back(32'h2200 + 32'(i));
        apply();
        for (int t = 0; t < 30 && fq[2].size() != 0; t++) step();
        repeat (2) step();
        for (int i = 0; i < 3; i++) fq[0].push_back(32'h0A0 + 32'(i));
        apply();
        for (int j = 0; j < 5; j++) begin
            step();
            #1;
            chk("hold_grant_out", bus.GRANT_OUT, 5'b00100);
            chk("hold_read_grant", bus.READ_GRANT, 0);
        end
        bus.HOLD_REQ[2] = 1'b0;
        for (int t = 0; t < 20 && log_ch.size() < 9; t++) step();
        chk("hold_count", log_ch.size(), 9);
        for (int i = 0; i < 6; i++)
            if (i < log_ch.size()) chk("hold_chan", log_ch[i], 2);
        if (log_ch.size() > 6) chk("hold_next", log_ch[6], 0);
        // mask drop mid-burst
        repeat (2) step();
        clr_log();
        for (int i = 0; i < 4; i++) fq[1].push_back(32'h1100 + 32'(i));
        for (int i = 0; i < 2; i++) fq[3].push_back(32'h3300 + 32'(i));
        apply();
        for (int t = 0; t < 10 && log_ch.size() < 1; t++) step();
        bus.CH_ENABLE[1] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("mask_read_grant1", bus.READ_GRANT[1], 1'b0);
            step();
        end
        n1 = 0;
        while (n1 < log_ch.size() && log_ch[n1] == 1) n1++;
        chk("mask_next", (n1 < log_ch.size()) ? log_ch[n1] : -1, 3);
        chk("mask_left", fq[1].size(), 4 - n1);
        fq[1].delete();
        apply();
        bus.CH_ENABLE = '1;
        repeat (6) step();
        // async reset mid-burst, then restart from channel 0
        clr_log();
        for (int i = 0; i < 6; i++) fq[4].push_back(32'h5500 + 32'(i));
        apply();
        for (int t = 0; t < 10 && log_ch.size() < 1; t++) step();
        step();
        #2;
        RSTn = 1'b0;
        #1;
        chk("arst_write_out", bus.WRITE_OUT, 0);
        chk("arst_data_out", bus.DATA_OUT, 0);
        chk("arst_channel_out", bus.CHANNEL_OUT, 0);
        chk("arst_grant_out", bus.GRANT_OUT, 0);
        chk("arst_read_grant", bus.READ_GRANT, 0);
        for (int k = 0; k < W; k++) fq[k].delete();
        step();
        step();
        fq[0].push_back(32'hC0);
        fq[3].push_back(32'hC3);
        fq[4].push_back(32'hC4);
        apply();
        clr_log();
        RSTn = 1'b1;
        for (int t = 0; t < 20 && log_ch.size() < 3; t++) step();
        chk("restart_count", log_ch.size(), 3);
        if (log_ch.size() >= 3) begin
            chk("restart_ch0", log_ch[0], 0);
            chk("restart_ch1", log_ch[1], 3);
            chk("restart_ch2", log_ch[2], 4);
        end
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
Parametrised round-robin arbiter that merges N first-word-fall-through readout FIFOs (FE receivers, TDC, TLU) into one data stream. It feeds the shared 32-to-8 data FIFO.
- Generalises the fixed-width arbiter: channel count and data width are parameters.
- Adds a per-channel enable mask, a bounded burst length, and hold-to-complete-event.
- Output is registered and tagged with the source channel index.

Parameters:
WIDTH, 5, number of input channels (1..16)
DSIZE, 32, data word width per channel
MAX_BURST, 16, max consecutive words granted to one channel before rotation (1..255; not enforced while HOLD_REQ asserted)
IDW, clog2(WIDTH) (min 1), width of CHANNEL_OUT

Ports:
CLK  in  1  single clock; all logic on rising edge
RSTn  in  1  asynchronous active-low reset
CH_ENABLE  in  WIDTH  per-channel enable mask; 0 = channel never granted
WRITE_REQ  in  WIDTH  channel k has a word available (FIFO not empty)
HOLD_REQ  in  WIDTH  channel k requests to keep the grant (event in progress)
DATA_IN  in  WIDTH*DSIZE  channel k data at bits [k*DSIZE +: DSIZE], valid while WRITE_REQ[k]
READ_GRANT  out  WIDTH  one-hot pop strobe to channel k FIFO
READY_OUT  in  1  downstream can accept a word this cycle
WRITE_OUT  out  1  DATA_OUT/CHANNEL_OUT valid, one cycle
DATA_OUT  out  DSIZE  registered data word
CHANNEL_OUT  out  IDW  index of the channel that produced DATA_OUT
GRANT_OUT  out  WIDTH  one-hot currently owning channel (0 in IDLE)

Behaviour:
- Reset (RSTn=0, async): state=IDLE, owner=0, last=WIDTH-1, burst_cnt=0. READ_GRANT=0, WRITE_OUT=0, DATA_OUT=0, CHANNEL_OUT=0, GRANT_OUT=0. Reset mid-burst drops the word in flight; no READ_GRANT during reset.
- eligible = WRITE_REQ & CH_ENABLE.
- States: IDLE, GRANT.
- IDLE: if eligible!=0, owner = first set bit searching last+1, last+2, … with wrap modulo WIDTH. Go to GRANT, burst_cnt=0. IDLE→GRANT costs one cycle.
- GRANT, pop condition: READ_GRANT[owner] = WRITE_REQ[owner] & CH_ENABLE[owner] & READY_OUT, combinational. All other READ_GRANT bits are 0, so READ_GRANT is at most one-hot.
- GRANT, on pop: next edge registers DATA_OUT=DATA_IN[owner], CHANNEL_OUT=owner, WRITE_OUT=1, burst_cnt+1 (saturating at 255). Latency is 1 cycle from pop to WRITE_OUT. WRITE_OUT=0 in any cycle without a pop; DATA_OUT holds its value.
- Release to IDLE (last=owner) at the edge when any of these holds:
  - CH_ENABLE[owner]=0.
  - WRITE_REQ[owner]=0 and HOLD_REQ[owner]=0.
  - A pop brings burst_cnt to MAX_BURST and HOLD_REQ[owner]=0.
- HOLD_REQ[owner]=1 keeps the grant even if WRITE_REQ[owner]=0 or burst_cnt ≥ MAX_BURST. Only CH_ENABLE=0 or reset breaks a hold.
- READY_OUT=0: no pop and no state change except release rules; burst_cnt frozen.
- Simultaneous: a pop and a release in the same cycle means the word is taken, then release. A release and a new request in the same cycle still passes through IDLE. Max throughput is 1 word/cycle within a burst, with a 1-cycle bubble per channel switch.
- HOLD_REQ on a non-owner channel is ignored.
- GRANT_OUT = onehot(owner) in GRANT, else 0.

Decomposition:
- Shared package: state encoding (IDLE/GRANT), clog2 function, MAX_BURST counter width constant (8).
- Sub-module rr_priority_select: combinational rotating-priority encoder; inputs request vector and last, outputs one-hot and index.
- The top block contains the FSM, burst counter and output register.

Test Plan:
- Reset: with RSTn low, drive WRITE_REQ=5'b11111 → all outputs 0. Release RSTn, then 5'b00001 with data 0xA0..0xA3 → WRITE_OUT on 4 consecutive cycles, CHANNEL_OUT=0, first word 2 cycles after the request.
- Fairness: MAX_BURST=4, channels 1,2,3 always requesting with enable=all → CHANNEL_OUT sequence 1,1,1,1,2,2,2,2,3,3,3,3,1…, one idle cycle between groups.
- Backpressure: READY_OUT low for 3 cycles mid-burst → READ_GRANT=0 and WRITE_OUT=0 for those cycles. No word lost or duplicated; burst_cnt resumes at its frozen value.
- Hold: HOLD_REQ[2]=1 with ch2 idle for 5 cycles while ch0 requests → ch2 keeps GRANT_OUT=5'b00100 and ch0 waits. The burst continues past MAX_BURST until hold drops.
- Mask: CH_ENABLE[1] cleared during a ch1 burst → no further READ_GRANT[1]; next grant goes to ch3 (next eligible).
- Async reset mid-burst at non-edge time → outputs 0 immediately. After release, arbitration restarts from channel 0.
